pipe_stage_regs: RTL
====================

Name: pipe_stage_regs

Overview:
- Parametrised, elastic successor to the fixed inter-stage pipeline registers (e.g. MEM/WB).
- Carries a data bundle, a control-flag bundle and a destination-register index from one stage to the next.
- Uses a valid/ready handshake with a two-entry skid buffer, so back-pressure never creates a combinational ready path.
- Adds a synchronous flush, which inserts a bubble on branch/jump redirect.

Parameters:
- DATA_W, 32, width of one data word.
- DATA_N, 5, number of data words per bundle (ALU result, jump PC, load data, imm, seq PC).
- CTRL_W, 6, width of the control-flag bundle (jal, jalr, lui, U_type, MemtoReg, RegWrite, ...).
- RD_W, 5, width of the destination-register index.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- flush, in, 1, synchronous kill of all held entries.
- in_valid, in, 1, upstream entry valid.
- in_ready, out, 1, stage can accept an entry.
- in_data, in, DATA_W*DATA_N, packed data words; word k occupies bits [k*DATA_W +: DATA_W].
- in_ctrl, in, CTRL_W, control flags.
- in_rd, in, RD_W, destination register.
- out_valid, out, 1, downstream entry valid.
- out_ready, in, 1, downstream accepts the entry.
- out_data, out, DATA_W*DATA_N, registered data.
- out_ctrl, out, CTRL_W, registered control flags.
- out_rd, out, RD_W, registered destination.
- occupancy, out, 2, entries held (0..2).

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Storage is a main register (drives the out_* ports) plus one skid register. Both hold {data, ctrl, rd, valid}.
- Reset values:
  - All main/skid fields are 0.
  - out_valid=0, out_data=0, out_ctrl=0, out_rd=0, occupancy=0.
  - State=EMPTY, so in_ready=1.
- in_ready is a pure function of registered state (in_ready = state!=FULL). It has no combinational dependency on out_ready.
- Latency: an entry accepted at edge N appears on out_* after edge N, provided the stage was EMPTY, or ONE with out_ready=1.
- Throughput: 1 entry/cycle while out_ready stays high.
- Transfer-in = in_valid&in_ready; transfer-out = out_valid&out_ready.
- State machine:
  - EMPTY: in_valid -> ONE, main<=in.
  - ONE, in_valid & out_ready: stay ONE, main<=in.
  - ONE, in_valid & !out_ready: -> FULL, skid<=in, main held.
  - ONE, !in_valid & out_ready: -> EMPTY, main.valid<=0.
  - ONE, neither: hold.
  - FULL (in_ready=0), out_ready: -> ONE, main<=skid, skid.valid<=0.
  - FULL, !out_ready: hold. in_valid is ignored and the upstream entry is not consumed.
- Ordering: entries leave strictly in arrival order. The skid entry is never overtaken.
- flush (highest priority, synchronous):
  - Next state is EMPTY; main.valid and skid.valid go to 0.
  - main.ctrl and skid.ctrl are cleared to 0, so RegWrite/MemtoReg can never leak.
  - An in_valid offered in the flush cycle is dropped. in_ready still reads per the current state, and upstream must treat the entry as killed.
  - A transfer-out in the flush cycle still counts as completed downstream.
- Data and rd fields are not cleared on flush; they hold their last value.
- occupancy = 0/1/2 for EMPTY/ONE/FULL, registered.
- Async reset asserted mid-transfer: everything returns to reset values immediately, and no entry survives.

Optional Feature:
- Macro: PIPE_CTRL_GATE_EN.
- Defined: out_ctrl = main.ctrl & {CTRL_W{out_valid}}. A drained or empty stage always presents zero control flags, even after a normal drain to EMPTY.
- Undefined: out_ctrl drives the main.ctrl register directly. After a drain it may hold stale flags, and the consumer must qualify them with out_valid.

Decomposition:
- Shared package (define.v extension):
  - zeroword/zero constants.
  - Default widths PIPE_DATA_W=32 and PIPE_RD_W=5.
  - State encodings ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - Control-bundle bit indices (CTRL_JAL=0, CTRL_JALR=1, CTRL_LUI=2, CTRL_UTYPE=3, CTRL_MEM2REG=4, CTRL_REGWR=5).
- One sub-module, pipe_entry_reg: a {valid, ctrl, rd, data} register with load enable and ctrl-clear. It is instantiated twice, once as main and once as skid.

Test Plan:
- Reset then idle: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0.
- Streaming with out_ready=1: push 4 entries on consecutive cycles (word0=0x10,0x20,0x30,0x40, ctrl=6'b100001). Each appears one cycle later, in order, with no bubbles.
- Back-pressure:
  - Push A=0x11 with out_ready=0. Next cycle push B=0x22: occupancy=2, in_ready=0, output holds A.
  - Offer C=0x33: not accepted.
  - Raise out_ready: outputs A, then B, then C.
- Flush while FULL with in_valid=1: next cycle out_valid=0, occupancy=0, out_ctrl=0, in_ready=1. The offered entry never appears at the output.
- Async reset pulsed mid-stream while occupancy=2: outputs go to zero immediately, without waiting for a clock edge. After release, in_ready=1.
- Drain to EMPTY after entry with ctrl=6'h3F:
  - With PIPE_CTRL_GATE_EN defined: out_ctrl=0.
  - Without it: out_ctrl=6'h3F while out_valid=0.

Source files
------------

// File: rtl/pipe_stage_regs_pkg.sv
// Shared definitions for the elastic inter-stage pipeline register.
// Holds the zero constants, default widths, handshake state encoding
// and the bit positions inside the control-flag bundle.
package pipe_stage_regs_pkg;

   localparam logic [31:0] zeroword = 32'h0000_0000;
   localparam logic        zero     = 1'b0;

   localparam int PIPE_DATA_W = 32;
   localparam int PIPE_RD_W   = 5;

   // Control-bundle bit positions
   localparam int CTRL_JAL     = 0;
   localparam int CTRL_JALR    = 1;
   localparam int CTRL_LUI     = 2;
   localparam int CTRL_UTYPE   = 3;
   localparam int CTRL_MEM2REG = 4;
   localparam int CTRL_REGWR   = 5;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } pipe_state_e;

   // Number of entries held in a given state
   function automatic logic [1:0] occ_of(input pipe_state_e st);
      case (st)
         ST_ONE:  occ_of = 2'd1;
         ST_FULL: occ_of = 2'd2;
         default: occ_of = 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_regs_entry.sv
// pipe_entry_reg: one {valid, ctrl, rd, data} storage slot.
// clr kills the slot (valid and ctrl to 0, data/rd kept), load writes every
// field, drop clears only valid. Priority: clr > load > drop.
module pipe_entry_reg
   import pipe_stage_regs_pkg::*;
#(
   parameter int DW = 160,
   parameter int CW = 6,
   parameter int RW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          load,
   input  logic          drop,
   input  logic          d_valid,
   input  logic [CW-1:0] d_ctrl,
   input  logic [RW-1:0] d_rd,
   input  logic [DW-1:0] d_data,
   output logic          q_valid,
   output logic [CW-1:0] q_ctrl,
   output logic [RW-1:0] q_rd,
   output logic [DW-1:0] q_data
);

   // Slot update: kill, load or drop the held entry
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_valid <= zero;
         q_ctrl  <= '0;
         q_rd    <= '0;
         q_data  <= '0;
      end else if (clr) begin
         q_valid <= zero;
         q_ctrl  <= '0;
      end else if (load) begin
         q_valid <= d_valid;
         q_ctrl  <= d_ctrl;
         q_rd    <= d_rd;
         q_data  <= d_data;
      end else if (drop) begin
         q_valid <= zero;
      end
   end

endmodule

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs: elastic pipeline register between two stages.
// A main slot drives the out_* ports and a skid slot absorbs the one entry
// that can arrive while the consumer stalls, so in_ready depends only on
// registered state.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; the producer holds its entry stable until in_ready is seen.
// flush kills both slots synchronously and drops any entry offered with it.
// Optional macro PIPE_CTRL_GATE_EN: when defined, out_ctrl is forced to zero
// whenever out_valid is low; otherwise it shows the main slot's flags as is.
module pipe_stage_regs
   import pipe_stage_regs_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int DATA_N = 5,
   parameter int CTRL_W = 6,
   parameter int RD_W   = PIPE_RD_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W*DATA_N-1:0] in_data,
   input  logic [CTRL_W-1:0]        in_ctrl,
   input  logic [RD_W-1:0]          in_rd,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_W*DATA_N-1:0] out_data,
   output logic [CTRL_W-1:0]        out_ctrl,
   output logic [RD_W-1:0]          out_rd,
   output logic [1:0]               occupancy
);

   localparam int DW = DATA_W * DATA_N;

   pipe_state_e state, state_nxt;

   logic          main_load, main_from_skid, main_drop;
   logic          skid_load, skid_drop;
   logic          main_valid, skid_valid;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
   logic [RD_W-1:0]   main_rd, skid_rd;
   logic [DW-1:0]     main_data, skid_data;

   logic          main_d_valid;
   logic [CTRL_W-1:0] main_d_ctrl;
   logic [RD_W-1:0]   main_d_rd;
   logic [DW-1:0]     main_d_data;

   assign in_ready = (state != ST_FULL);

   // Next-state and slot-control decode from state and both handshake sides
   always_comb begin
      state_nxt      = state;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      main_drop      = 1'b0;
      skid_load      = 1'b0;
      skid_drop      = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (in_valid) begin
               main_load = 1'b1;
               state_nxt = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_valid && out_ready) begin
               main_load = 1'b1;
            end else if (in_valid) begin
               skid_load = 1'b1;
               state_nxt = ST_FULL;
            end else if (out_ready) begin
               main_drop = 1'b1;
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (out_ready) begin
               main_load      = 1'b1;
               main_from_skid = 1'b1;
               skid_drop      = 1'b1;
               state_nxt      = ST_ONE;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
      if (flush) state_nxt = ST_EMPTY;
   end

   // Main slot source: the skid entry drains first so it is never overtaken
   always_comb begin
      main_d_valid = main_from_skid ? skid_valid : 1'b1;
      main_d_ctrl  = main_from_skid ? skid_ctrl  : in_ctrl;
      main_d_rd    = main_from_skid ? skid_rd    : in_rd;
      main_d_data  = main_from_skid ? skid_data  : in_data;
   end

   // Handshake state and its registered occupancy count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_EMPTY;
         occupancy <= 2'd0;
      end else begin
         state     <= state_nxt;
         occupancy <= occ_of(state_nxt);
      end
   end

   pipe_entry_reg #(.DW(DW), .CW(CTRL_W), .RW(RD_W)) u_main (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (flush),
      .load    (main_load),
      .drop    (main_drop),
      .d_valid (main_d_valid),
      .d_ctrl  (main_d_ctrl),
      .d_rd    (main_d_rd),
      .d_data  (main_d_data),
      .q_valid (main_valid),
      .q_ctrl  (main_ctrl),
      .q_rd    (main_rd),
      .q_data  (main_data)
   );

   pipe_entry_reg #(.DW(DW), .CW(CTRL_W), .RW(RD_W)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (flush),
      .load    (skid_load),
      .drop    (skid_drop),
      .d_valid (1'b1),
      .d_ctrl  (in_ctrl),
      .d_rd    (in_rd),
      .d_data  (in_data),
      .q_valid (skid_valid),
      .q_ctrl  (skid_ctrl),
      .q_rd    (skid_rd),
      .q_data  (skid_data)
   );

   assign out_valid = main_valid;
   assign out_data  = main_data;
   assign out_rd    = main_rd;

`ifdef PIPE_CTRL_GATE_EN
   assign out_ctrl = main_ctrl & {CTRL_W{main_valid}};
`else
   assign out_ctrl = main_ctrl;
`endif

endmodule
